fetch_buffer: RTL and testbench

Instruction prefetch buffer between instruction fetch (PC + instruction memory) and decode. It captures {pc, instruction} pairs from fetch into a small circular FIFO and presents them in order to decode through a valid/ready handshake. This decouples fetch from decode stalls. On a taken branch, the EX-stage redirect flushes every buffered (wrong-path) entry in a single cycle.

---
 rtl/fetch_buffer.sv | 93 +++++++++
 tb/tb_fetch_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: circular FIFO of {pc, inst} pairs between fetch
// and decode, with a single-cycle flush for EX-stage redirects.
module fetch_buffer #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_BITS = 5,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               F_valid,
  input  logic [PC_BITS-1:0] F_pc,
  input  logic [XLEN-1:0]    F_inst,
  output logic               F_ready,
  output logic               D_valid,
  output logic [PC_BITS-1:0] D_pc,
  output logic [XLEN-1:0]    D_inst,
  input  logic               D_ready,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PC_BITS-1:0] pc_mem_q   [DEPTH];
  logic [XLEN-1:0]    inst_mem_q [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push, pop;

  // Ready/valid come from registered occupancy only, so F_ready never
  // depends on D_ready.
  always_comb begin
    F_ready = (count_q != CNT_W'(DEPTH));
    D_valid = (count_q != '0);
    D_pc    = pc_mem_q[rd_ptr_q];
    D_inst  = inst_mem_q[rd_ptr_q];
    count   = count_q;
    push    = F_valid & F_ready;
    pop     = D_valid & D_ready;
  end

  // Next-state for pointers and occupancy; flush overrides any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointer overflow is the wrap.
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: cleared on reset so the head reads zero; left intact by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (!flush && push) begin
      pc_mem_q[wr_ptr_q]   <= F_pc;
      inst_mem_q[wr_ptr_q] <= F_inst;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed and randomised checks for fetch_buffer.
module tb_fetch_buffer;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_BITS = 5;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  logic               clk;
  logic               rst;
  logic               flush;
  logic               F_valid;
  logic [PC_BITS-1:0] F_pc;
  logic [XLEN-1:0]    F_inst;
  logic               F_ready;
  logic               D_valid;
  logic [PC_BITS-1:0] D_pc;
  logic [XLEN-1:0]    D_inst;
  logic               D_ready;
  logic [CNT_W-1:0]   count;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic [PC_BITS-1:0] pc;
    logic [XLEN-1:0]    inst;
  } entry_t;

  entry_t model_q[$];

  fetch_buffer #(
    .XLEN   (XLEN),
    .PC_BITS(PC_BITS),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .F_valid(F_valid),
    .F_pc   (F_pc),
    .F_inst (F_inst),
    .F_ready(F_ready),
    .D_valid(D_valid),
    .D_pc   (D_pc),
    .D_inst (D_inst),
    .D_ready(D_ready),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input int pc, input logic [XLEN-1:0] inst);
    F_valid = 1'b1;
    F_pc    = PC_BITS'(pc);
    F_inst  = inst;
  endtask

  initial begin
    logic fv, dr, fl, fr, psh, pp;
    entry_t e;

    tests_run    = 0;
    tests_failed = 0;
    rst     = 1'b1;
    flush   = 1'b0;
    F_valid = 1'b0;
    F_pc    = '0;
    F_inst  = '0;
    D_ready = 1'b0;

    // Reset values
    step();
    step();
    chk("rst_count",   64'(count),   64'd0);
    chk("rst_dvalid",  64'(D_valid), 64'd0);
    chk("rst_dpc",     64'(D_pc),    64'd0);
    chk("rst_dinst",   64'(D_inst),  64'd0);
    chk("rst_fready",  64'(F_ready), 64'd1);
    rst = 1'b0;

    // 1. Single entry, 1-cycle latency
    drive_push(3, 32'h0000_1234);
    step();
    F_valid = 1'b0;
    chk("t1_dvalid", 64'(D_valid), 64'd1);
    chk("t1_dpc",    64'(D_pc),    64'd3);
    chk("t1_dinst",  64'(D_inst),  64'h1234);
    chk("t1_count",  64'(count),   64'd1);
    D_ready = 1'b1;
    step();
    D_ready = 1'b0;
    chk("t1_empty",  64'(D_valid), 64'd0);

    // 2. Fill and stall
    for (int i = 0; i < 4; i++) begin
      drive_push(i, 32'(100 + i));
      step();
    end
    chk("t2_full_count",  64'(count),   64'd4);
    chk("t2_full_fready", 64'(F_ready), 64'd0);
    drive_push(4, 32'd104);
    step();
    chk("t2_stall_count", 64'(count), 64'd4);
    chk("t2_stall_head",  64'(D_pc),  64'd0);
    D_ready = 1'b1;
    step();
    D_ready = 1'b0;
    chk("t2_pop_count",  64'(count),   64'd3);
    chk("t2_pop_fready", 64'(F_ready), 64'd1);
    chk("t2_pop_head",   64'(D_pc),    64'd1);
    step();
    F_valid = 1'b0;
    chk("t2_refill_count", 64'(count), 64'd4);
    D_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t2_drain_pc",   64'(D_pc),   64'(k));
      chk("t2_drain_inst", 64'(D_inst), 64'(100 + k));
      step();
    end
    D_ready = 1'b0;
    chk("t2_drained", 64'(count), 64'd0);

    // 3. Streaming with pointer wrap
    D_ready = 1'b1;
    drive_push(0, 32'hA000_0000);
    step();
    for (int i = 1; i < 20; i++) begin
      chk("t3_stream_pc",    64'(D_pc),   64'(i - 1));
      chk("t3_stream_inst",  64'(D_inst), 64'(32'hA000_0000 | 32'(i - 1)));
      chk("t3_stream_count", 64'(count),  64'd1);
      drive_push(i, 32'hA000_0000 | 32'(i));
      step();
    end
    F_valid = 1'b0;
    chk("t3_last_pc", 64'(D_pc), 64'd19);
    step();
    D_ready = 1'b0;
    chk("t3_end_count", 64'(count), 64'd0);

    // 4. Flush with simultaneous push and pop
    for (int i = 10; i < 13; i++) begin
      drive_push(i, 32'(i));
      step();
    end
    F_valid = 1'b0;
    chk("t4_pre_count", 64'(count), 64'd3);
    flush   = 1'b1;
    D_ready = 1'b1;
    drive_push(9, 32'd9);
    step();
    flush   = 1'b0;
    F_valid = 1'b0;
    D_ready = 1'b0;
    chk("t4_fl_count",  64'(count),   64'd0);
    chk("t4_fl_dvalid", 64'(D_valid), 64'd0);
    chk("t4_fl_fready", 64'(F_ready), 64'd1);
    drive_push(20, 32'd20);
    step();
    F_valid = 1'b0;
    chk("t4_redirect_valid", 64'(D_valid), 64'd1);
    chk("t4_redirect_pc",    64'(D_pc),    64'd20);
    chk("t4_redirect_count", 64'(count),   64'd1);
    D_ready = 1'b1;
    step();
    D_ready = 1'b0;
    chk("t4_no_pc9", 64'(D_valid), 64'd0);

    // Back-to-back flushes, each dropping the offered entry
    drive_push(1, 32'd1);
    step();
    flush = 1'b1;
    drive_push(2, 32'd2);
    step();
    chk("t4_bb1_count", 64'(count), 64'd0);
    drive_push(3, 32'd3);
    step();
    flush   = 1'b0;
    F_valid = 1'b0;
    chk("t4_bb2_count", 64'(count), 64'd0);

    // 5. Reset mid-stream
    drive_push(5, 32'd5);
    step();
    drive_push(6, 32'd6);
    step();
    chk("t5_pre_count", 64'(count), 64'd2);
    rst = 1'b1;
    drive_push(7, 32'd7);
    step();
    rst     = 1'b0;
    F_valid = 1'b0;
    chk("t5_count",  64'(count),   64'd0);
    chk("t5_dvalid", 64'(D_valid), 64'd0);
    chk("t5_dpc",    64'(D_pc),    64'd0);
    chk("t5_dinst",  64'(D_inst),  64'd0);
    drive_push(21, 32'd21);
    step();
    F_valid = 1'b0;
    chk("t5_new_pc",    64'(D_pc),  64'd21);
    chk("t5_new_count", 64'(count), 64'd1);
    D_ready = 1'b1;
    step();
    D_ready = 1'b0;

    // 6. Randomised scoreboard against a queue model
    model_q.delete();
    for (int c = 0; c < 10000; c++) begin
      chk("t6_count", 64'(count), 64'(model_q.size()));
      chk("t6_count_max", 64'(count <= CNT_W'(DEPTH)), 64'd1);
      chk("t6_dvalid", 64'(D_valid), 64'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        chk("t6_head_pc",   64'(D_pc),   64'(model_q[0].pc));
        chk("t6_head_inst", 64'(D_inst), 64'(model_q[0].inst));
      end
      fv = 1'($urandom_range(0, 1));
      dr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 63) == 0);
      F_valid = fv;
      F_pc    = PC_BITS'($urandom);
      F_inst  = $urandom;
      D_ready = dr;
      flush   = fl;
      fr  = (model_q.size() != int'(DEPTH));
      psh = fv && fr;
      pp  = dr && (model_q.size() != 0);
      if (fl) begin
        model_q.delete();
      end else begin
        if (pp) void'(model_q.pop_front());
        if (psh) begin
          e.pc   = F_pc;
          e.inst = F_inst;
          model_q.push_back(e);
        end
      end
      step();
    end
    F_valid = 1'b0;
    D_ready = 1'b0;
    flush   = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
